onehot_decoder: RTL
===================

Name: onehot_decoder

Overview:
- Inverse of the classifier's one-hot encoder stage: takes the 10-bit one-hot class vector plus the reference label and produces a binary class index with error flags.
- Sits at the classifier output, ahead of the result bus and the accuracy statistics.
- Two-stage valid/ready pipeline with downstream backpressure.
- Accumulates running "total" and "correct" counters for on-chip accuracy measurement.

Parameters:
N_CLASS, 10, number of classes (width of d_in)
IDX_W, 4, width of class index and label (ceil(log2(N_CLASS)), at least 1)
COUNT_W, 16, width of statistics counters

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
input_valid  input  1  d_in/label valid
input_ready  output  1  block can accept input this cycle
d_in  input  N_CLASS  one-hot class vector, bit i = class i
label  input  IDX_W  ground-truth class for this sample
output_valid  output  1  d_out/flags valid
output_ready  input  1  downstream accepts result
d_out  output  IDX_W  decoded class index
err_zero  output  1  d_in had no bit set
err_multi  output  1  d_in had two or more bits set
correct  output  1  no error and d_out == label
clear_stats  input  1  synchronous clear of the statistics counters
total_count  output  COUNT_W  results accepted downstream
correct_count  output  COUNT_W  accepted results with correct=1

Behaviour:
- Reset (rst=0, asynchronous): all pipeline valids = 0 and all outputs = 0, including input_ready. Once rst=1, input_ready follows the rule below (1 on the first clock with an empty pipeline).
- Stall: stall = output_valid & !output_ready. input_ready = !stall.
- When !stall, both stages advance together:
  - Stage 1 captures d_in, label and input_valid.
  - Stage 2 captures the decode of stage 1.
- When stall, all stage registers hold.
- Input handshake: input_valid & input_ready.
- Output handshake: output_valid & output_ready.
- Latency: 2 clocks from the input handshake to output_valid=1 with no stall. Throughput is 1 result per clock.
- A bubble (input_valid=0 while advancing) propagates as valid=0. It holds no registers beyond the valid bit.
- Decode, from the stage-1 vector:
  - popcount 0: err_zero=1, err_multi=0, d_out = all ones (4'hF), correct=0.
  - popcount 1: d_out = index of the set bit, both error flags 0.
  - popcount ≥2: err_multi=1, d_out = lowest set index, matching the encoder's lowest-index tie priority; correct=0.
  - correct = !err_zero & !err_multi & (d_out == label).
  - A label ≥ N_CLASS never matches.
- Outputs d_out, err_zero, err_multi and correct are registered. They are stable while output_valid=1 and !output_ready. They keep their last value when output_valid=0.
- Statistics, on each output handshake:
  - total_count increments by 1.
  - correct_count increments by 1 if correct=1.
  - Both counters saturate at 2^COUNT_W-1 and do not wrap.
- clear_stats=1 sets both counters to 0 on the next edge. It has priority over a same-cycle handshake, whose result is not counted. clear_stats does not affect the data pipeline.
- Reset mid-operation: in-flight samples are dropped and counters go to 0. No output_valid is produced for dropped samples.

Decomposition:
- Shared package (onehot_pkg), also imported by the encoder side:
  - N_CLASS_DEF=10 and IDX_W_DEF=4.
  - INVALID_IDX = all ones.
  - typedef class_vec_t (logic [N_CLASS-1:0]) and class_idx_t (logic [IDX_W-1:0]).
- Sub-module onehot_to_idx: purely combinational. Outputs the lowest-set index, zero flag and multi flag; instantiated once in stage 2.
- Counters and pipeline stay in the top.

Test Plan:
- Reset/idle: rst=0 then 1, no input → input_ready=1 after the first clock; output_valid, d_out, flags and counters all 0.
- Single sample: d_in=10'b0000100000, label=5, output_ready=1 → 2 clocks later output_valid=1, d_out=5, correct=1; total_count=1 and correct_count=1 after the handshake.
- Errors: d_in=0 → d_out=4'hF, err_zero=1. d_in=10'b1000000100 with label=2 → d_out=2, err_multi=1, correct=0.
- Back-to-back with backpressure:
  - Stimulus: stream classes 0..9 every cycle with label = class; output_ready low for 3 cycles mid-stream.
  - Outputs hold during the stall, input_ready=0 during the stall, and no sample is lost or duplicated.
  - Final counts: total_count=10, correct_count=10.
- Saturation and clear:
  - With COUNT_W=3, run 9 correct samples → both counters = 7.
  - Assert clear_stats in the same cycle as a handshake → both counters = 0.
- Async reset mid-stream: pull rst low with 2 samples in flight → outputs go to 0 immediately; after release, no output_valid appears until new input is given.

Source files
------------

// File: rtl/onehot_decoder_pkg.sv
// Shared definitions for the classifier one-hot encode/decode pair.
//   N_CLASS_DEF : default number of classes (one-hot vector width)
//   IDX_W_DEF   : default width of a class index / label
//   INVALID_IDX : index reported when no class bit is set
//   class_vec_t : one-hot class vector, bit i = class i
//   class_idx_t : binary class index
package onehot_pkg;

    localparam int N_CLASS_DEF = 10;
    localparam int IDX_W_DEF   = 4;

    localparam logic [IDX_W_DEF-1:0] INVALID_IDX = '1;

    typedef logic [N_CLASS_DEF-1:0] class_vec_t;
    typedef logic [IDX_W_DEF-1:0]   class_idx_t;

endpackage

// File: rtl/onehot_decoder_to_idx.sv
// onehot_to_idx: combinational one-hot to binary index conversion.
//   vec   : input  N_CLASS  class vector
//   idx   : output IDX_W    lowest set bit index, all ones when vec == 0
//   zero  : output 1        no bit set
//   multi : output 1        two or more bits set
module onehot_to_idx
    import onehot_pkg::*;
#(
    parameter int N_CLASS = N_CLASS_DEF,
    parameter int IDX_W   = IDX_W_DEF
) (
    input  logic [N_CLASS-1:0] vec,
    output logic [IDX_W-1:0]   idx,
    output logic               zero,
    output logic               multi
);

    // Scan from the top down so the lowest set bit wins, matching the
    // encoder's tie priority.
    always_comb begin
        idx = '1;
        for (int i = N_CLASS - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

    assign zero  = ~|vec;
    // Clearing the lowest set bit leaves something only if >= 2 bits were set.
    assign multi = |(vec & (vec - N_CLASS'(1)));

endmodule

// File: rtl/onehot_decoder.sv
// onehot_decoder: two-stage valid/ready decoder from the classifier's one-hot
// class vector to a binary index, with error flags and accuracy counters.
//   clk, rst                    : clock, asynchronous active-low reset
//   input_valid / input_ready   : input handshake for d_in and label
//   d_in, label                 : one-hot class vector, ground-truth class
//   output_valid / output_ready : output handshake for d_out and flags
//   d_out, err_zero, err_multi  : decoded index and error flags
//   correct                     : error-free and d_out == label
//   clear_stats                 : synchronous clear of the counters
//   total_count, correct_count  : saturating counts of accepted results
module onehot_decoder
    import onehot_pkg::*;
#(
    parameter int N_CLASS = N_CLASS_DEF,
    parameter int IDX_W   = IDX_W_DEF,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               input_valid,
    output logic               input_ready,
    input  logic [N_CLASS-1:0] d_in,
    input  logic [IDX_W-1:0]   label,
    output logic               output_valid,
    input  logic               output_ready,
    output logic [IDX_W-1:0]   d_out,
    output logic               err_zero,
    output logic               err_multi,
    output logic               correct,
    input  logic               clear_stats,
    output logic [COUNT_W-1:0] total_count,
    output logic [COUNT_W-1:0] correct_count
);

    logic               ready_en;
    logic               stall;
    logic               s1_valid;
    logic [N_CLASS-1:0] s1_vec;
    logic [IDX_W-1:0]   s1_label;
    logic [IDX_W-1:0]   dec_idx;
    logic               dec_zero;
    logic               dec_multi;
    logic               label_ok;
    logic               dec_correct;
    logic               out_fire;

    assign stall    = output_valid & ~output_ready;
    assign out_fire = output_valid & output_ready;

    // ready_en keeps input_ready low while in reset and until the first
    // clock after release.
    assign input_ready = ready_en & ~stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    onehot_to_idx #(
        .N_CLASS (N_CLASS),
        .IDX_W   (IDX_W)
    ) u_to_idx (
        .vec   (s1_vec),
        .idx   (dec_idx),
        .zero  (dec_zero),
        .multi (dec_multi)
    );

    // Out-of-range labels can never be a correct answer.
    assign label_ok    = 32'(s1_label) < N_CLASS;
    assign dec_correct = ~dec_zero & ~dec_multi & label_ok & (dec_idx == s1_label);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid     <= 1'b0;
            s1_vec       <= '0;
            s1_label     <= '0;
            output_valid <= 1'b0;
            d_out        <= '0;
            err_zero     <= 1'b0;
            err_multi    <= 1'b0;
            correct      <= 1'b0;
        end else if (!stall) begin
            s1_valid <= input_valid & input_ready;
            if (input_valid & input_ready) begin
                s1_vec   <= d_in;
                s1_label <= label;
            end
            output_valid <= s1_valid;
            // Bubbles only move the valid bit; result registers keep the
            // last delivered value.
            if (s1_valid) begin
                d_out     <= dec_idx;
                err_zero  <= dec_zero;
                err_multi <= dec_multi;
                correct   <= dec_correct;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            total_count   <= '0;
            correct_count <= '0;
        end else if (clear_stats) begin
            total_count   <= '0;
            correct_count <= '0;
        end else if (out_fire) begin
            if (total_count != '1) begin
                total_count <= total_count + COUNT_W'(1);
            end
            if (correct && (correct_count != '1)) begin
                correct_count <= correct_count + COUNT_W'(1);
            end
        end
    end

endmodule
